input_matrix_scanner: RTL and testbench

//  Parametrised key-matrix multiplexer: the game CPU strobes mux_clock, the block steps a one-hot row select
//  and presents the addressed row's key state on an input port. Generalises the fixed 7-row mahjong input mux
//  to any ROWS x COLS matrix, with selectable polarity and a press latch so taps shorter than a scan are seen.

---
 rtl/input_matrix_scanner_pkg.sv | 33 +++
 rtl/input_matrix_scanner_if.sv | 14 +
 rtl/input_matrix_scanner_edge_detect.sv | 13 +
 rtl/input_matrix_scanner.sv | 64 ++++++
 tb/tb_input_matrix_scanner.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/input_matrix_scanner_pkg.sv
// input_matrix_scanner_pkg: shared row-width helper, default matrix size and mahjong key map
package input_matrix_scanner_pkg;
  localparam int DAKKOCHAN_ROWS = 7;
  localparam int DAKKOCHAN_COLS = 8;
  function automatic int row_w(input int rows);
    return rows > 1 ? $clog2(rows) : 1;
  endfunction
  typedef struct packed {
    logic [3:0] row;
    logic [2:0] col;
  } key_pos_t;
  localparam key_pos_t KEY_A     = '{row: 4'd0, col: 3'd0};
  localparam key_pos_t KEY_B     = '{row: 4'd0, col: 3'd1};
  localparam key_pos_t KEY_C     = '{row: 4'd0, col: 3'd2};
  localparam key_pos_t KEY_D     = '{row: 4'd0, col: 3'd3};
  localparam key_pos_t KEY_E     = '{row: 4'd1, col: 3'd0};
  localparam key_pos_t KEY_F     = '{row: 4'd1, col: 3'd1};
  localparam key_pos_t KEY_G     = '{row: 4'd1, col: 3'd2};
  localparam key_pos_t KEY_H     = '{row: 4'd1, col: 3'd3};
  localparam key_pos_t KEY_I     = '{row: 4'd2, col: 3'd0};
  localparam key_pos_t KEY_J     = '{row: 4'd2, col: 3'd1};
  localparam key_pos_t KEY_K     = '{row: 4'd2, col: 3'd2};
  localparam key_pos_t KEY_L     = '{row: 4'd2, col: 3'd3};
  localparam key_pos_t KEY_M     = '{row: 4'd3, col: 3'd0};
  localparam key_pos_t KEY_N     = '{row: 4'd3, col: 3'd1};
  localparam key_pos_t KEY_KAN   = '{row: 4'd4, col: 3'd0};
  localparam key_pos_t KEY_PON   = '{row: 4'd4, col: 3'd1};
  localparam key_pos_t KEY_CHI   = '{row: 4'd4, col: 3'd2};
  localparam key_pos_t KEY_REACH = '{row: 4'd5, col: 3'd0};
  localparam key_pos_t KEY_RON   = '{row: 4'd5, col: 3'd1};
  localparam key_pos_t KEY_START = '{row: 4'd6, col: 3'd0};
  localparam key_pos_t KEY_COIN  = '{row: 4'd6, col: 3'd1};
endpackage

// File: rtl/input_matrix_scanner_if.sv
// input_matrix_scanner_if: key event port from the PS/2 decoder to the scanner
interface input_matrix_scanner_if
  import input_matrix_scanner_pkg::*;
#(
  parameter int ROWS = DAKKOCHAN_ROWS
);
  localparam int RW = row_w(ROWS);
  logic          key_valid;
  logic [RW-1:0] key_row;
  logic [2:0]    key_col;
  logic          key_pressed;
  modport master(output key_valid, key_row, key_col, key_pressed);
  modport slave(input key_valid, key_row, key_col, key_pressed);
endinterface

// File: rtl/input_matrix_scanner_edge_detect.sv
// input_matrix_scanner_edge_detect: one-cycle strobe on the selected edge of a clk_sys-domain level
module input_matrix_scanner_edge_detect #(
  parameter bit FALLING = 1'b0
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic level,
  output logic pulse
);
  logic prev;
  always_ff @(posedge clk_sys) prev <= level;
  assign pulse = !RESET && (FALLING ? (prev && !level) : (!prev && level));
endmodule

// File: rtl/input_matrix_scanner.sv
// input_matrix_scanner: row-stepping key matrix mux with polarity select and press latch
module input_matrix_scanner
  import input_matrix_scanner_pkg::*;
#(
  parameter int ROWS        = DAKKOCHAN_ROWS,
  parameter int COLS        = DAKKOCHAN_COLS,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit LATCH_PRESS = 1'b1,
  parameter bit MUX_EDGE    = 1'b0,
  localparam int RW         = row_w(ROWS)
) (
  input  logic                   clk_sys,
  input  logic                   RESET,
  input  logic                   enable,
  input  logic [RW-1:0]          start_row,
  input  logic                   mux_clock,
  input_matrix_scanner_if.slave  key,
  output logic [RW-1:0]          row_idx,
  output logic [ROWS-1:0]        row_sel,
  output logic [COLS-1:0]        row_data,
  output logic                   scan_wrap
);
  logic            edge_hit, adv, last, wr;
  logic [RW-1:0]   idx_nx, rst_idx;
  logic [COLS-1:0] wmask, vis;
  logic [COLS-1:0] ks[ROWS], pd[ROWS], ks_nx[ROWS], pd_nx[ROWS];
  input_matrix_scanner_edge_detect #(.FALLING(MUX_EDGE)) u_edge (
    .clk_sys(clk_sys),
    .RESET  (RESET),
    .level  (mux_clock),
    .pulse  (edge_hit)
  );
  assign adv     = edge_hit && enable;
  assign last    = 32'(row_idx) == ROWS - 1;
  assign idx_nx  = adv ? (last ? '0 : row_idx + 1'b1) : row_idx;
  assign rst_idx = 32'(start_row) < ROWS ? start_row : '0;
  assign wr      = key.key_valid && 32'(key.key_row) < ROWS && 32'(key.key_col) < COLS;
  assign wmask   = wr ? COLS'(1) << key.key_col : '0;
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      ks_nx[r] = 32'(key.key_row) == r ? (key.key_pressed ? ks[r] | wmask : ks[r] & ~wmask) : ks[r];
      pd_nx[r] = ((adv && 32'(row_idx) == r) ? '0 : pd[r])
               | ((LATCH_PRESS && key.key_pressed && 32'(key.key_row) == r) ? wmask : '0);
    end
  end
  assign vis = ks_nx[idx_nx] | pd_nx[idx_nx];
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      row_idx   <= rst_idx;
      row_sel   <= ROWS'(1) << rst_idx;
      row_data  <= ACTIVE_LOW ? '1 : '0;
      scan_wrap <= 1'b0;
      ks        <= '{default: '0};
      pd        <= '{default: '0};
    end else begin
      row_idx   <= idx_nx;
      row_sel   <= ROWS'(1) << idx_nx;
      row_data  <= ACTIVE_LOW ? ~vis : vis;
      scan_wrap <= adv && last;
      ks        <= ks_nx;
      pd        <= pd_nx;
    end
  end
endmodule

// File: tb/tb_input_matrix_scanner.sv
// tb_input_matrix_scanner: scoreboard bench for two scanner configurations sharing one stimulus stream
module tb_input_matrix_scanner;
  typedef struct {
    int idx;
    int sel;
    int data;
    bit wrap;
  } exp_t;
  logic       clk_sys = 0, RESET = 1, enable = 1, mux_clock = 0;
  logic       key_valid = 0, key_pressed = 0;
  logic [2:0] start_row = 3, key_row = 0, key_col = 0;
  logic [2:0] row_idx_a, row_idx_b;
  logic [6:0] row_sel_a;
  logic [4:0] row_sel_b;
  logic [7:0] row_data_a;
  logic [5:0] row_data_b;
  logic       scan_wrap_a, scan_wrap_b;
  int   n_checks = 0, n_errors = 0;
  exp_t qa[$], qb[$];
  int   rows[2] = '{7, 5};
  int   cols[2] = '{8, 6};
  bit   al[2] = '{1'b1, 1'b0};
  bit   lp[2] = '{1'b1, 1'b0};
  bit   fe[2] = '{1'b0, 1'b1};
  int   m_idx[2];
  int   m_ks[2][16];
  int   m_pd[2][16];
  bit   m_prev[2];
  always #5 clk_sys = ~clk_sys;
  input_matrix_scanner_if #(.ROWS(7)) kif_a ();
  input_matrix_scanner_if #(.ROWS(5)) kif_b ();
  assign kif_a.key_valid   = key_valid;
  assign kif_a.key_row     = key_row;
  assign kif_a.key_col     = key_col;
  assign kif_a.key_pressed = key_pressed;
  assign kif_b.key_valid   = key_valid;
  assign kif_b.key_row     = key_row;
  assign kif_b.key_col     = key_col;
  assign kif_b.key_pressed = key_pressed;
  input_matrix_scanner dut_a (
    .clk_sys(clk_sys), .RESET(RESET), .enable(enable), .start_row(start_row),
    .mux_clock(mux_clock), .key(kif_a), .row_idx(row_idx_a), .row_sel(row_sel_a),
    .row_data(row_data_a), .scan_wrap(scan_wrap_a)
  );
  input_matrix_scanner #(.ROWS(5), .COLS(6), .ACTIVE_LOW(1'b0), .LATCH_PRESS(1'b0), .MUX_EDGE(1'b1)) dut_b (
    .clk_sys(clk_sys), .RESET(RESET), .enable(enable), .start_row(start_row),
    .mux_clock(mux_clock), .key(kif_b), .row_idx(row_idx_b), .row_sel(row_sel_b),
    .row_data(row_data_b), .scan_wrap(scan_wrap_b)
  );
  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model(input int d, output exp_t x);
    int mask = (1 << cols[d]) - 1;
    int old  = m_idx[d];
    int vis;
    bit a;
    x.wrap = 1'b0;
    if (RESET) begin
      m_idx[d] = (start_row < rows[d]) ? int'(start_row) : 0;
      for (int r = 0; r < 16; r++) begin
        m_ks[d][r] = 0;
        m_pd[d][r] = 0;
      end
      m_prev[d] = mux_clock;
      x.idx  = m_idx[d];
      x.sel  = 1 << m_idx[d];
      x.data = al[d] ? mask : 0;
      return;
    end
    a = enable && (fe[d] ? (m_prev[d] && !mux_clock) : (!m_prev[d] && mux_clock));
    m_prev[d] = mux_clock;
    if (a) begin
      m_pd[d][old] = 0;
      x.wrap = (old == rows[d] - 1);
      m_idx[d] = x.wrap ? 0 : old + 1;
    end
    if (key_valid && key_row < rows[d] && key_col < cols[d]) begin
      if (key_pressed) begin
        m_ks[d][key_row] |= 1 << key_col;
        if (lp[d]) m_pd[d][key_row] |= 1 << key_col;
      end else m_ks[d][key_row] &= ~(1 << key_col);
    end
    vis = m_ks[d][m_idx[d]] | m_pd[d][m_idx[d]];
    x.idx  = m_idx[d];
    x.sel  = 1 << m_idx[d];
    x.data = al[d] ? (~vis & mask) : vis;
  endtask
  task automatic cyc();
    exp_t x;
    model(0, x);
    qa.push_back(x);
    model(1, x);
    qb.push_back(x);
    @(negedge clk_sys);
  endtask
  task automatic pulse();
    mux_clock = 1;
    cyc();
    mux_clock = 0;
    cyc();
  endtask
  task automatic adv_to_a(input int target);
    while (m_idx[0] != target) pulse();
  endtask
  task automatic key_evt(input int r, input int c, input bit p);
    key_valid   = 1;
    key_row     = 3'(r);
    key_col     = 3'(c);
    key_pressed = p;
    cyc();
    key_valid = 0;
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk_sys);
      #1;
      if (qa.size() != 0 && qb.size() != 0) begin
        x = qa.pop_front();
        chk("a_row_idx", row_idx_a, x.idx);
        chk("a_row_sel", row_sel_a, x.sel);
        chk("a_row_data", row_data_a, x.data);
        chk("a_scan_wrap", scan_wrap_a, x.wrap);
        x = qb.pop_front();
        chk("b_row_idx", row_idx_b, x.idx);
        chk("b_row_sel", row_sel_b, x.sel);
        chk("b_row_data", row_data_b, x.data);
        chk("b_scan_wrap", scan_wrap_b, x.wrap);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    RESET = 1;
    start_row = 3;
    cyc();
    cyc();
    chk("rst_idx", row_idx_a, 3);
    chk("rst_sel", row_sel_a, 7'b0001000);
    chk("rst_data", row_data_a, 8'hFF);
    chk("rst_wrap", scan_wrap_a, 0);
    chk("rst_data_b", row_data_b, 0);
    RESET = 0;
    cyc();
    chk("rst_hold_idx", row_idx_a, 3);
    RESET = 1;
    start_row = 0;
    cyc();
    RESET = 0;
    for (int k = 0; k < 7; k++) begin
      mux_clock = 1;
      cyc();
      chk("walk_idx", row_idx_a, (k + 1) % 7);
      chk("walk_wrap", scan_wrap_a, (k == 6) ? 1 : 0);
      mux_clock = 0;
      cyc();
    end
    adv_to_a(5);
    key_evt(2, 1, 1);
    cyc();
    key_evt(2, 1, 0);
    adv_to_a(2);
    chk("tap_seen", row_data_a, 8'hFD);
    pulse();
    adv_to_a(2);
    chk("tap_cleared", row_data_a, 8'hFF);
    key_evt(4, 0, 1);
    for (int s = 0; s < 2; s++) begin
      adv_to_a(4);
      chk("hold_seen", row_data_a, 8'hFE);
      pulse();
    end
    key_evt(4, 0, 0);
    adv_to_a(4);
    chk("hold_released", row_data_a, 8'hFF);
    enable = 0;
    repeat (3) pulse();
    chk("frozen_idx", row_idx_a, 4);
    enable = 1;
    pulse();
    chk("resume_idx", row_idx_a, 5);
    key_evt(7, 0, 1);
    repeat (7) begin
      pulse();
      chk("oor_row", row_data_a, 8'hFF);
    end
    key_evt(0, 7, 1);
    key_evt(0, 4, 1);
    while (m_idx[1] != 0) pulse();
    chk("b_active_high", row_data_b, 6'h10);
    repeat (2000) begin
      RESET       = ($urandom_range(0, 199) == 0);
      start_row   = 3'($urandom_range(0, 7));
      enable      = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0) mux_clock = ~mux_clock;
      key_valid   = ($urandom_range(0, 3) == 0);
      key_row     = 3'($urandom_range(0, 7));
      key_col     = 3'($urandom_range(0, 7));
      key_pressed = 1'($urandom_range(0, 1));
      cyc();
    end
    RESET = 0;
    key_valid = 0;
    repeat (3) @(negedge clk_sys);
    chk("drain", qa.size() + qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
